// File: rtl/axi_lite_arb2.sv
// ============================================================================
// Module   : axi_lite_arb2
// Brief    : Two-master / one-slave AXI-lite arbiter with independent read and
//            write paths. Define ARB_FIXED_PRIO_EN for fixed m0-first priority
//            (default build: round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_lite_arb2 #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  // master 0
  input  logic [ADDR_W-1:0]     m0_aw_addr,
  input  logic                  m0_aw_valid,
  output logic                  m0_aw_ready,
  input  logic [DATA_W-1:0]     m0_w_data,
  input  logic [DATA_W/8-1:0]   m0_w_strb,
  input  logic                  m0_w_valid,
  output logic                  m0_w_ready,
  output logic [1:0]            m0_b_resp,
  output logic                  m0_b_valid,
  input  logic                  m0_b_ready,
  input  logic [ADDR_W-1:0]     m0_ar_addr,
  input  logic                  m0_ar_valid,
  output logic                  m0_ar_ready,
  output logic [DATA_W-1:0]     m0_r_data,
  output logic [1:0]            m0_r_resp,
  output logic                  m0_r_valid,
  input  logic                  m0_r_ready,

  // master 1
  input  logic [ADDR_W-1:0]     m1_aw_addr,
  input  logic                  m1_aw_valid,
  output logic                  m1_aw_ready,
  input  logic [DATA_W-1:0]     m1_w_data,
  input  logic [DATA_W/8-1:0]   m1_w_strb,
  input  logic                  m1_w_valid,
  output logic                  m1_w_ready,
  output logic [1:0]            m1_b_resp,
  output logic                  m1_b_valid,
  input  logic                  m1_b_ready,
  input  logic [ADDR_W-1:0]     m1_ar_addr,
  input  logic                  m1_ar_valid,
  output logic                  m1_ar_ready,
  output logic [DATA_W-1:0]     m1_r_data,
  output logic [1:0]            m1_r_resp,
  output logic                  m1_r_valid,
  input  logic                  m1_r_ready,

  // slave
  output logic [ADDR_W-1:0]     s_aw_addr,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [DATA_W-1:0]     s_w_data,
  output logic [DATA_W/8-1:0]   s_w_strb,
  output logic                  s_w_valid,
  input  logic                  s_w_ready,
  input  logic [1:0]            s_b_resp,
  input  logic                  s_b_valid,
  output logic                  s_b_ready,
  output logic [ADDR_W-1:0]     s_ar_addr,
  output logic                  s_ar_valid,
  input  logic                  s_ar_ready,
  input  logic [DATA_W-1:0]     s_r_data,
  input  logic [1:0]            s_r_resp,
  input  logic                  s_r_valid,
  output logic                  s_r_ready
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  // Grant encoding: 0 = m0, 1 = m1
  logic rd_gnt_q, rd_gnt_d;
  logic wr_gnt_q, wr_gnt_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic w_rd_pick;
  logic w_wr_pick;

  // --------------------------------------------------------------------------
  // Arbitration decision for a new request
  // --------------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
  assign w_rd_pick = ~m0_ar_valid;
  assign w_wr_pick = ~m0_aw_valid;
`else
  logic rd_last_q, rd_last_d;
  logic wr_last_q, wr_last_d;

  // On a tie the master that was not served last wins; otherwise the sole requester.
  assign w_rd_pick = (m0_ar_valid && m1_ar_valid) ? ~rd_last_q : m1_ar_valid;
  assign w_wr_pick = (m0_aw_valid && m1_aw_valid) ? ~wr_last_q : m1_aw_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_last_q <= 1'b1;
      wr_last_q <= 1'b1;
    end else begin
      rd_last_q <= rd_last_d;
      wr_last_q <= wr_last_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Payload routing; only the handshake signals depend on state
  // --------------------------------------------------------------------------
  assign s_ar_addr = rd_gnt_q ? m1_ar_addr : m0_ar_addr;
  assign m0_r_data = s_r_data;
  assign m1_r_data = s_r_data;
  assign m0_r_resp = s_r_resp;
  assign m1_r_resp = s_r_resp;

  assign s_aw_addr = wr_gnt_q ? m1_aw_addr : m0_aw_addr;
  assign s_w_data  = wr_gnt_q ? m1_w_data  : m0_w_data;
  assign s_w_strb  = wr_gnt_q ? m1_w_strb  : m0_w_strb;
  assign m0_b_resp = s_b_resp;
  assign m1_b_resp = s_b_resp;

  // --------------------------------------------------------------------------
  // Read path FSM
  // --------------------------------------------------------------------------
  always_comb begin
    logic ar_v;
    logic r_rdy;
    rd_state_d  = rd_state_q;
    rd_gnt_d    = rd_gnt_q;
`ifndef ARB_FIXED_PRIO_EN
    rd_last_d   = rd_last_q;
`endif
    s_ar_valid  = 1'b0;
    s_r_ready   = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    m0_r_valid  = 1'b0;
    m1_r_valid  = 1'b0;
    ar_v        = rd_gnt_q ? m1_ar_valid : m0_ar_valid;
    r_rdy       = rd_gnt_q ? m1_r_ready  : m0_r_ready;

    case (rd_state_q)
      R_IDLE: begin
        if (m0_ar_valid || m1_ar_valid) begin
          rd_gnt_d   = w_rd_pick;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        s_ar_valid  = ar_v;
        m0_ar_ready = ~rd_gnt_q & s_ar_ready;
        m1_ar_ready =  rd_gnt_q & s_ar_ready;
        if (ar_v && s_ar_ready) begin
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        s_r_ready  = r_rdy;
        m0_r_valid = ~rd_gnt_q & s_r_valid;
        m1_r_valid =  rd_gnt_q & s_r_valid;
        if (s_r_valid && r_rdy) begin
          rd_state_d = R_IDLE;
`ifndef ARB_FIXED_PRIO_EN
          rd_last_d  = rd_gnt_q;
`endif
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write path FSM; AW and W run in parallel, each masked once accepted
  // --------------------------------------------------------------------------
  always_comb begin
    logic aw_v;
    logic w_v;
    logic b_rdy;
    logic aw_hs;
    logic w_hs;
    wr_state_d  = wr_state_q;
    wr_gnt_d    = wr_gnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
`ifndef ARB_FIXED_PRIO_EN
    wr_last_d   = wr_last_q;
`endif
    s_aw_valid  = 1'b0;
    s_w_valid   = 1'b0;
    s_b_ready   = 1'b0;
    m0_aw_ready = 1'b0;
    m1_aw_ready = 1'b0;
    m0_w_ready  = 1'b0;
    m1_w_ready  = 1'b0;
    m0_b_valid  = 1'b0;
    m1_b_valid  = 1'b0;
    aw_v        = wr_gnt_q ? m1_aw_valid : m0_aw_valid;
    w_v         = wr_gnt_q ? m1_w_valid  : m0_w_valid;
    b_rdy       = wr_gnt_q ? m1_b_ready  : m0_b_ready;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        // A lone w_valid never starts a grant; it waits for its AW.
        if (m0_aw_valid || m1_aw_valid) begin
          wr_gnt_d   = w_wr_pick;
          wr_state_d = W_XFER;
        end
      end
      W_XFER: begin
        s_aw_valid  = aw_v & ~aw_done_q;
        s_w_valid   = w_v  & ~w_done_q;
        m0_aw_ready = ~wr_gnt_q & ~aw_done_q & s_aw_ready;
        m1_aw_ready =  wr_gnt_q & ~aw_done_q & s_aw_ready;
        m0_w_ready  = ~wr_gnt_q & ~w_done_q  & s_w_ready;
        m1_w_ready  =  wr_gnt_q & ~w_done_q  & s_w_ready;
        aw_hs       = aw_v & ~aw_done_q & s_aw_ready;
        w_hs        = w_v  & ~w_done_q  & s_w_ready;
        aw_done_d   = aw_done_q | aw_hs;
        w_done_d    = w_done_q  | w_hs;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_b_ready  = b_rdy;
        m0_b_valid = ~wr_gnt_q & s_b_valid;
        m1_b_valid =  wr_gnt_q & s_b_valid;
        if (s_b_valid && b_rdy) begin
          wr_state_d = W_IDLE;
`ifndef ARB_FIXED_PRIO_EN
          wr_last_d  = wr_gnt_q;
`endif
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_arb2.sv
// ============================================================================
// Module   : tb_axi_lite_arb2
// Brief    : Directed self-checking bench for axi_lite_arb2 with a small
//            memory slave model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_lite_arb2;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int TMO    = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_aw_addr, m1_aw_addr, s_aw_addr;
  logic m0_aw_valid, m1_aw_valid, s_aw_valid;
  logic m0_aw_ready, m1_aw_ready, s_aw_ready;
  logic [DATA_W-1:0] m0_w_data, m1_w_data, s_w_data;
  logic [1:0] m0_w_strb, m1_w_strb, s_w_strb;
  logic m0_w_valid, m1_w_valid, s_w_valid;
  logic m0_w_ready, m1_w_ready, s_w_ready;
  logic [1:0] m0_b_resp, m1_b_resp, s_b_resp;
  logic m0_b_valid, m1_b_valid, s_b_valid;
  logic m0_b_ready, m1_b_ready, s_b_ready;
  logic [ADDR_W-1:0] m0_ar_addr, m1_ar_addr, s_ar_addr;
  logic m0_ar_valid, m1_ar_valid, s_ar_valid;
  logic m0_ar_ready, m1_ar_ready, s_ar_ready;
  logic [DATA_W-1:0] m0_r_data, m1_r_data, s_r_data;
  logic [1:0] m0_r_resp, m1_r_resp, s_r_resp;
  logic m0_r_valid, m1_r_valid, s_r_valid;
  logic m0_r_ready, m1_r_ready, s_r_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  axi_lite_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_aw_addr(m0_aw_addr), .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
    .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
    .m0_b_resp(m0_b_resp), .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
    .m0_ar_addr(m0_ar_addr), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m1_aw_addr(m1_aw_addr), .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
    .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
    .m1_b_resp(m1_b_resp), .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
    .m1_ar_addr(m1_ar_addr), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready)
  );

  // All handshake outputs of the DUT, used to check the quiescent state
  wire [14:0] ctl_out = {s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready,
                         m0_aw_ready, m0_w_ready, m0_b_valid, m0_ar_ready, m0_r_valid,
                         m1_aw_ready, m1_w_ready, m1_b_valid, m1_ar_ready, m1_r_valid};

  // --------------------------------------------------------------------------
  // Memory slave model: mem[i] = 0x1000 + i after reset
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [0:255];
  logic s_aw_got, s_w_got;
  logic [7:0] s_waddr;
  logic [DATA_W-1:0] s_wdata;
  logic [1:0] s_wstrb;
  int n_saw, n_sw;

  wire slv_aw_hs = s_aw_valid & s_aw_ready;
  wire slv_w_hs  = s_w_valid & s_w_ready;
  wire [7:0] wa  = slv_aw_hs ? s_aw_addr[7:0] : s_waddr;
  wire [DATA_W-1:0] wd = slv_w_hs ? s_w_data : s_wdata;
  wire [1:0] ws  = slv_w_hs ? s_w_strb : s_wstrb;
  wire [DATA_W-1:0] merged = {ws[1] ? wd[15:8] : mem[wa][15:8], ws[0] ? wd[7:0] : mem[wa][7:0]};

  assign s_aw_ready = !s_aw_got && !s_b_valid;
  assign s_w_ready  = !s_w_got && !s_b_valid;
  assign s_ar_ready = !s_r_valid;
  assign s_b_resp   = 2'b00;
  assign s_r_resp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_aw_got  <= 1'b0;
      s_w_got   <= 1'b0;
      s_waddr   <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      s_b_valid <= 1'b0;
      s_r_valid <= 1'b0;
      s_r_data  <= '0;
      n_saw     <= 0;
      n_sw      <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
    end else begin
      if (slv_aw_hs) begin
        s_aw_got <= 1'b1;
        s_waddr  <= s_aw_addr[7:0];
        n_saw    <= n_saw + 1;
      end
      if (slv_w_hs) begin
        s_w_got <= 1'b1;
        s_wdata <= s_w_data;
        s_wstrb <= s_w_strb;
        n_sw    <= n_sw + 1;
      end
      if ((slv_aw_hs || s_aw_got) && (slv_w_hs || s_w_got) && !s_b_valid) begin
        mem[wa]   <= merged;
        s_b_valid <= 1'b1;
        s_aw_got  <= 1'b0;
        s_w_got   <= 1'b0;
      end
      if (s_b_valid && s_b_ready) s_b_valid <= 1'b0;
      if (s_ar_valid && s_ar_ready) begin
        s_r_valid <= 1'b1;
        s_r_data  <= mem[s_ar_addr[7:0]];
      end else if (s_r_valid && s_r_ready) begin
        s_r_valid <= 1'b0;
      end
    end
  end

  // Event log: 1 = slave AR handshake, 2 = m0 R handshake, 3 = m1 R handshake
  int ev[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (s_ar_valid && s_ar_ready) ev.push_back(1);
      if (m0_r_valid && m0_r_ready) ev.push_back(2);
      if (m1_r_valid && m1_r_ready) ev.push_back(3);
    end
  end

  // --------------------------------------------------------------------------
  // Master helpers
  // --------------------------------------------------------------------------
  task automatic mread(input int m, input logic [ADDR_W-1:0] a,
                       output logic [DATA_W-1:0] d, output int lat);
    int t0;
    int k;
    t0 = cyc;
    d  = '0;
    if (m == 0) begin m0_ar_addr = a; m0_ar_valid = 1'b1; m0_r_ready = 1'b1; end
    else        begin m1_ar_addr = a; m1_ar_valid = 1'b1; m1_r_ready = 1'b1; end
    for (k = 0; k < TMO; k++) begin
      if ((m == 0) ? m0_ar_ready : m1_ar_ready) break;
      @(negedge clk);
    end
    if (k == TMO) begin
      n_tests++; n_fail++;
      $display("FAIL rd_ar_timeout m%0d: ar_ready not seen, required within %0d cycles", m, TMO);
    end
    @(negedge clk);
    if (m == 0) m0_ar_valid = 1'b0; else m1_ar_valid = 1'b0;
    for (k = 0; k < TMO; k++) begin
      if ((m == 0) ? m0_r_valid : m1_r_valid) break;
      @(negedge clk);
    end
    if (k == TMO) begin
      n_tests++; n_fail++;
      $display("FAIL rd_r_timeout m%0d: r_valid not seen, required within %0d cycles", m, TMO);
    end
    d   = (m == 0) ? m0_r_data : m1_r_data;
    lat = cyc - t0;
    @(negedge clk);
  endtask

  task automatic mwrite(input int m, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [1:0] s, input int w_lead,
                        output logic [1:0] resp, output int lat);
    int  t0;
    int  k;
    bit  aw_p, w_p, hs_aw, hs_w;
    resp = 2'bxx;
    if (m == 0) begin m0_w_data = d; m0_w_strb = s; m0_w_valid = 1'b1; m0_b_ready = 1'b1; end
    else        begin m1_w_data = d; m1_w_strb = s; m1_w_valid = 1'b1; m1_b_ready = 1'b1; end
    for (int i = 0; i < w_lead; i++) begin
      @(negedge clk);
      n_tests++;
      if ({s_w_valid, (m == 0) ? m0_w_ready : m1_w_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL w_before_aw_held m%0d: s_w_valid/w_ready=%b, required 00", m,
                 {s_w_valid, (m == 0) ? m0_w_ready : m1_w_ready});
      end
    end
    t0 = cyc;
    if (m == 0) begin m0_aw_addr = a; m0_aw_valid = 1'b1; end
    else        begin m1_aw_addr = a; m1_aw_valid = 1'b1; end
    aw_p = 1'b1;
    w_p  = 1'b1;
    for (k = 0; k < TMO && (aw_p || w_p); k++) begin
      hs_aw = aw_p && ((m == 0) ? m0_aw_ready : m1_aw_ready);
      hs_w  = w_p  && ((m == 0) ? m0_w_ready  : m1_w_ready);
      @(negedge clk);
      if (hs_aw) begin aw_p = 1'b0; if (m == 0) m0_aw_valid = 1'b0; else m1_aw_valid = 1'b0; end
      if (hs_w)  begin w_p  = 1'b0; if (m == 0) m0_w_valid  = 1'b0; else m1_w_valid  = 1'b0; end
    end
    if (aw_p || w_p) begin
      n_tests++; n_fail++;
      $display("FAIL wr_addr_data_timeout m%0d: aw/w pending=%b%b, required 00", m, aw_p, w_p);
    end
    for (k = 0; k < TMO; k++) begin
      if ((m == 0) ? m0_b_valid : m1_b_valid) break;
      @(negedge clk);
    end
    if (k == TMO) begin
      n_tests++; n_fail++;
      $display("FAIL wr_b_timeout m%0d: b_valid not seen, required within %0d cycles", m, TMO);
    end
    resp = (m == 0) ? m0_b_resp : m1_b_resp;
    lat  = cyc - t0;
    @(negedge clk);
    if (m == 0) m0_b_ready = 1'b0; else m1_b_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    m0_ar_valid = 1'b1;
    m1_aw_valid = 1'b1;
    m1_w_valid  = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ctl_out !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0000", ctl_out);
    end
    rst = 1'b0;
    m0_ar_valid = 1'b0;
    m1_aw_valid = 1'b0;
    m1_w_valid  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl_out !== 15'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, required 0000", ctl_out);
    end
  endtask

  task automatic test_contention;
    logic [DATA_W-1:0] d0, d1;
    int l0, l1;
    logic [15:0] code;
    ev.delete();
    fork
      mread(0, 18'h00040, d0, l0);
      mread(1, 18'h00041, d1, l1);
    join
    code = '0;
    foreach (ev[i]) code = {code[11:0], 4'(ev[i])};
    n_tests++;
    if (ev.size() != 4 || code !== 16'h1213) begin
      n_fail++;
      $display("FAIL contention_order: got %0d events code %h, required 4 events code 1213", ev.size(), code);
    end
    n_tests++;
    if ({d0, d1} !== {16'h1040, 16'h1041}) begin
      n_fail++;
      $display("FAIL contention_data: got %h %h, required 1040 1041", d0, d1);
    end
  endtask

  task automatic test_round_robin;
    logic [31:0] code;
    logic [31:0] exp_code;
    int nr;
`ifdef ARB_FIXED_PRIO_EN
    exp_code = 32'h0000_1111;
`else
    exp_code = 32'h0101_0101;
`endif
    ev.delete();
    fork
      begin
        logic [DATA_W-1:0] d;
        int l;
        for (int i = 0; i < 4; i++) begin
          mread(0, 18'h00010 + 18'(i), d, l);
          n_tests++;
          if (d !== 16'h1010 + 16'(i)) begin
            n_fail++;
            $display("FAIL rr_data_m0_%0d: got %h, required %h", i, d, 16'h1010 + 16'(i));
          end
        end
      end
      begin
        logic [DATA_W-1:0] d;
        int l;
        for (int i = 0; i < 4; i++) begin
          mread(1, 18'h00020 + 18'(i), d, l);
          n_tests++;
          if (d !== 16'h1020 + 16'(i)) begin
            n_fail++;
            $display("FAIL rr_data_m1_%0d: got %h, required %h", i, d, 16'h1020 + 16'(i));
          end
        end
      end
    join
    code = '0;
    nr   = 0;
    foreach (ev[i]) if (ev[i] != 1) begin
      code = {code[27:0], 4'(ev[i] - 2)};
      nr++;
    end
    n_tests++;
    if (nr != 8 || code !== exp_code) begin
      n_fail++;
      $display("FAIL rr_grant_order: got %0d reads order %h, required 8 reads order %h", nr, code, exp_code);
    end
  endtask

  task automatic test_single_read;
    m0_ar_addr  = 18'h00123;
    m0_ar_valid = 1'b1;
    m0_r_ready  = 1'b1;
    #1;
    n_tests++;
    if (s_ar_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_arb_latency: s_ar_valid=%b, required 0", s_ar_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({s_ar_valid, s_ar_addr} !== {1'b1, 18'h00123}) begin
      n_fail++;
      $display("FAIL single_s_ar: got valid %b addr %h, required 1 00123", s_ar_valid, s_ar_addr);
    end
    n_tests++;
    if ({m0_ar_ready, m1_ar_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ar_ready: got %b, required 10", {m0_ar_ready, m1_ar_ready});
    end
    @(negedge clk);
    m0_ar_valid = 1'b0;
    n_tests++;
    if ({m0_r_valid, m1_r_valid, m0_r_data} !== {2'b10, 16'h1023}) begin
      n_fail++;
      $display("FAIL single_r_route: got r_valid %b data %h, required 10 1023",
               {m0_r_valid, m1_r_valid}, m0_r_data);
    end
    @(negedge clk);
    n_tests++;
    if (ctl_out !== 15'h0) begin
      n_fail++;
      $display("FAIL single_back_to_idle: got %h, required 0000", ctl_out);
    end
  endtask

  task automatic test_write_w_first;
    logic [1:0] resp;
    int l, saw0, sw0;
    logic [DATA_W-1:0] d;
    saw0 = n_saw;
    sw0  = n_sw;
    mwrite(1, 18'h00010, 16'hdead, 2'b11, 2, resp, l);
    repeat (2) @(negedge clk);
    n_tests++;
    if (n_saw - saw0 != 1 || n_sw - sw0 != 1) begin
      n_fail++;
      $display("FAIL wfirst_slave_beats: got aw %0d w %0d, required aw 1 w 1", n_saw - saw0, n_sw - sw0);
    end
    n_tests++;
    if (resp !== 2'b00) begin
      n_fail++;
      $display("FAIL wfirst_b_resp: got %b, required 00", resp);
    end
    mread(0, 18'h00010, d, l);
    n_tests++;
    if (d !== 16'hdead) begin
      n_fail++;
      $display("FAIL wfirst_readback: got %h, required dead", d);
    end
  endtask

  task automatic test_concurrent;
    logic [1:0] resp;
    logic [DATA_W-1:0] d;
    int lw, lr;
    fork
      mwrite(0, 18'h00030, 16'h5a5a, 2'b01, 0, resp, lw);
      mread(1, 18'h00031, d, lr);
    join
    n_tests++;
    if (lw != 2 || lr != 2) begin
      n_fail++;
      $display("FAIL concurrent_latency: got wr %0d rd %0d, required 2 2", lw, lr);
    end
    n_tests++;
    if (d !== 16'h1031) begin
      n_fail++;
      $display("FAIL concurrent_rd_data: got %h, required 1031", d);
    end
    mread(0, 18'h00030, d, lr);
    n_tests++;
    if (d !== 16'h105a) begin
      n_fail++;
      $display("FAIL concurrent_strb_readback: got %h, required 105a", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [DATA_W-1:0] d0, d1;
    int l0, l1, k;
    mread(0, 18'h00050, d0, l0);
    m0_ar_addr  = 18'h00051;
    m0_ar_valid = 1'b1;
    m0_r_ready  = 1'b0;
    for (k = 0; k < TMO; k++) begin
      if (m0_ar_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    m0_ar_valid = 1'b0;
    for (k = 0; k < TMO; k++) begin
      if (m0_r_valid) break;
      @(negedge clk);
    end
    n_tests++;
    if (m0_r_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_resp: m0_r_valid=%b, required 1", m0_r_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (ctl_out !== 15'h0) begin
      n_fail++;
      $display("FAIL rstmid_async_clear: got %h, required 0000", ctl_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ev.delete();
    fork
      mread(0, 18'h00052, d0, l0);
      mread(1, 18'h00053, d1, l1);
    join
    n_tests++;
    if (ev.size() < 2 || ev[1] != 2) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: got first r event %0d, required 2 (m0)",
               (ev.size() < 2) ? -1 : ev[1]);
    end
    n_tests++;
    if ({d0, d1} !== {16'h1052, 16'h1053}) begin
      n_fail++;
      $display("FAIL rstmid_data: got %h %h, required 1052 1053", d0, d1);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_aw_addr = '0; m0_aw_valid = 1'b0; m0_w_data = '0; m0_w_strb = '0; m0_w_valid = 1'b0;
    m0_b_ready = 1'b0; m0_ar_addr = '0; m0_ar_valid = 1'b0; m0_r_ready = 1'b0;
    m1_aw_addr = '0; m1_aw_valid = 1'b0; m1_w_data = '0; m1_w_strb = '0; m1_w_valid = 1'b0;
    m1_b_ready = 1'b0; m1_ar_addr = '0; m1_ar_valid = 1'b0; m1_r_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_contention();
    test_round_robin();
    test_single_read();
    test_write_w_first();
    test_concurrent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000ns, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/axi_lite_arb2.md
Name: axi_lite_arb2

Overview:
- Two-master, one-slave AXI-lite arbiter. It lets uart_debug (m0) and a second requester (m1, e.g. CPU or video fetch) share one memory slave (bram_axi or sram_axi).
- Read and write paths are arbitrated independently. Each path grants one master at a time and holds the grant until that transaction's response handshake completes.
- Sits between the masters and the memory AXI slave. Simple mux/demux plus per-path FSMs, no buffering of data.

Parameters:
- ADDR_W, 18, address width on all ports
- DATA_W, 16, data width; strobe width is DATA_W/8

Ports:
- Prefix p is one of m0, m1 (master side) or s (slave side). Direction is given as m:/s:.
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- p_aw_addr  m:in s:out  ADDR_W  write address
- p_aw_valid  m:in s:out  1
- p_aw_ready  m:out s:in  1
- p_w_data  m:in s:out  DATA_W
- p_w_strb  m:in s:out  DATA_W/8
- p_w_valid  m:in s:out  1
- p_w_ready  m:out s:in  1
- p_b_resp  m:out s:in  2
- p_b_valid  m:out s:in  1
- p_b_ready  m:in s:out  1
- p_ar_addr  m:in s:out  ADDR_W
- p_ar_valid  m:in s:out  1
- p_ar_ready  m:out s:in  1
- p_r_data  m:out s:in  DATA_W
- p_r_resp  m:out s:in  2
- p_r_valid  m:out s:in  1
- p_r_ready  m:in s:out  1

Behaviour:
- Reset (async, rst=1): both FSMs go to IDLE; rd_last and wr_last = 1, so m0 wins the first contention. All valid/ready outputs are 0 while rst=1 and in IDLE. Data, addr, resp and strb outputs are don't-care but must not be X-propagating into valids.
- Read FSM states: R_IDLE, R_ADDR, R_RESP.
  - R_IDLE: all read valids/readies out are 0. If any mx_ar_valid=1: register rd_gnt by round-robin (requester not equal to rd_last wins ties) and go to R_ADDR. Arbitration latency is 1 cycle.
  - R_ADDR: s_ar_* = granted master's ar_*; granted m_ar_ready = s_ar_ready; other master's ar_ready = 0. On s_ar_valid & s_ar_ready go to R_RESP.
  - R_RESP: s_ar_valid = 0. Granted m_r_* = s_r_*; s_r_ready = granted m_r_ready; other master's r_valid = 0. On r handshake: go to R_IDLE, rd_last = rd_gnt.
- Write FSM states: W_IDLE, W_XFER, W_RESP.
  - Grant is decided only on mx_aw_valid. A master asserting w_valid alone waits, holding w_valid.
  - W_XFER: AW and W are forwarded in parallel from the granted master. Flags aw_done and w_done are set on the respective slave handshake; once a flag is set, that channel's s_*_valid and m_*_ready are forced 0. When both flags are set go to W_RESP and clear the flags. The slave may accept AW and W in any order or the same cycle.
  - W_RESP: b routed to the granted master as for R. On handshake: go to W_IDLE, wr_last = wr_gnt.
- The ungranted master always sees ready=0 and valid=0 on all channels of that path.
- Read and write paths never interact. Concurrent read by one master and write by the other is permitted.
- Minimum per-transaction overhead: 1 idle/arb cycle. Back-to-back from the same master with no contention: IDLE, ADDR, RESP repeat.
- Reset mid-transaction: FSMs abort to IDLE immediately. The slave is also reset by the same reset domain.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: m0 always wins simultaneous requests; rd_last and wr_last are unused. Suits the debug port overriding traffic.
- Undefined: round-robin as above.

Test Plan:
- m0 read of addr 0x00123 alone → s_ar_addr=0x00123 with s_ar_valid one cycle after m0_ar_valid. Slave data returns on m0_r_data; m1_r_valid stays 0.
- m0 and m1 assert ar_valid in the same cycle right after reset → m0 granted first. m1's AR reaches the slave only after m0's R handshake.
- Both masters hold continuous read requests, 4 each → grants alternate m0,m1,m0,m1,... With ARB_FIXED_PRIO_EN: all 4 m0 reads complete before any m1 read.
- m1 raises w_valid (data 0xdead, strb 2'b11) 2 cycles before aw_valid (addr 0x00010) → exactly one slave AW and one slave W, m1_b_valid, b_resp=0. A subsequent m0 read of 0x00010 returns 0xdead.
- m0 write and m1 read issued in the same cycle → both complete with no added stall on either path.
- rst pulsed while read FSM is in R_RESP → m0/m1/s valids and readies go to 0 asynchronously. After release, next contention is granted to m0.
